// File: rtl/panel_pkg.sv
// panel_pkg: shared encodings for the stage indicator panel.
// Optional macro STAGE_PANEL_KEY_BEEP_EN adds the KEY state (key-click beep).
package panel_pkg;

  // Washer program run state as reported by the main controller.
  typedef enum logic [1:0] {
    RS_IDLE  = 2'd0,
    RS_RUN   = 2'd1,
    RS_PAUSE = 2'd2,
    RS_DONE  = 2'd3
  } run_state_t;

  // Buzzer sequencer states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
`ifdef STAGE_PANEL_KEY_BEEP_EN
    KEY   = 3'd1,
`endif
    D_ON  = 3'd2,
    D_OFF = 3'd3,
    D_GAP = 3'd4
  } buzz_state_t;

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/blink_gen.sv
// blink_gen: half-period prescaler driving the running-stage blink phase.
// phase is the value the phase flop takes at this edge, so a registered
// consumer sampling it shows the new phase in the same cycle as this block.
module blink_gen import panel_pkg::*; #(
  parameter int HALF = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic phase
);

  localparam int CW = cnt_width(HALF);

  logic [CW-1:0] r_cnt;
  logic          r_phase;
  logic          w_wrap;

  assign w_wrap = (r_cnt == CW'(HALF - 1));
  assign phase  = restart ? 1'b1 : (w_wrap ? ~r_phase : r_phase);

  // Free-running prescaler; restart realigns to a fresh high phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_phase <= 1'b1;
    end else if (restart) begin
      r_cnt   <= '0;
      r_phase <= 1'b1;
    end else if (w_wrap) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt   <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/stage_panel.sv
// stage_panel: program-stage lights, start light and buzzer sequencer.
// Define STAGE_PANEL_KEY_BEEP_EN to enable the key-click beep (KEY state).
module stage_panel import panel_pkg::*; #(
  parameter int STAGES          = 3,
  parameter int CLK_HZ          = 100_000_000,
  parameter int BEEP_GROUPS     = 3,
  parameter int BEEPS_PER_GROUP = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        power,
  input  logic [STAGES-1:0]           stage_mask,
  input  logic [$clog2(STAGES)-1:0]   cur_stage,
  input  run_state_t                  run_state,
  input  logic                        key_evt,
  output logic [STAGES-1:0]           stage_light,
  output logic                        start_light,
  output logic                        buzzer,
  output logic                        busy
);

  localparam int BEEP_LEN = CLK_HZ / 4;
  localparam int GAP_LEN  = CLK_HZ / 2;
  localparam int CW       = cnt_width(GAP_LEN);
  localparam int BW       = cnt_width(BEEPS_PER_GROUP);
  localparam int GW       = cnt_width(BEEP_GROUPS);

  buzz_state_t       r_state, w_state_next;
  logic [CW-1:0]     r_cnt, w_cnt_next;
  logic [BW-1:0]     r_beep, w_beep_next;
  logic [GW-1:0]     r_group, w_group_next;
  run_state_t        r_run_prev;
  logic [STAGES-1:0] r_stage_light, w_stage_next;
  logic              r_start_light, r_buzzer, r_busy;
  logic              w_buzzer_next, w_busy_next;
  logic              w_restart, w_done_edge, w_phase, w_cur_ok;

`ifndef STAGE_PANEL_KEY_BEEP_EN
  logic w_key_unused;
  assign w_key_unused = key_evt;
`endif

  // While unpowered the prescaler is held cleared; run entry restarts it high.
  assign w_restart   = !power || ((run_state == RS_RUN) && (r_run_prev != RS_RUN));
  assign w_done_edge = power && (run_state == RS_DONE) && (r_run_prev != RS_DONE);
  assign w_cur_ok    = (int'(cur_stage) < STAGES);

  blink_gen #(.HALF(CLK_HZ / 2)) u_blink (
    .clk     (clk),
    .reset   (reset),
    .restart (w_restart),
    .phase   (w_phase)
  );

  // Stage lights: mask, with the running stage replaced by the blink phase.
  always_comb begin
    w_stage_next = stage_mask;
    if ((run_state == RS_RUN) && w_cur_ok)
      w_stage_next[cur_stage] = w_phase;
  end

  // Buzzer sequencer next-state and next-output decode.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_beep_next  = r_beep;
    w_group_next = r_group;
    if (!power) begin
      w_state_next = IDLE;
      w_cnt_next   = '0;
      w_beep_next  = '0;
      w_group_next = '0;
    end else if (w_done_edge) begin
      w_state_next = D_ON;
      w_cnt_next   = '0;
      w_beep_next  = '0;
      w_group_next = '0;
    end else begin
      case (r_state)
        IDLE: begin
`ifdef STAGE_PANEL_KEY_BEEP_EN
          if (key_evt) begin
            w_state_next = KEY;
            w_cnt_next   = '0;
          end
`endif
        end
`ifdef STAGE_PANEL_KEY_BEEP_EN
        KEY: begin
          if (r_cnt == CW'(BEEP_LEN - 1)) begin
            w_state_next = IDLE;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next   = r_cnt + CW'(1);
          end
        end
`endif
        D_ON, D_OFF, D_GAP: begin
          if (run_state != RS_DONE) begin
            w_state_next = IDLE;
            w_cnt_next   = '0;
            w_beep_next  = '0;
            w_group_next = '0;
          end else if (r_state == D_ON) begin
            if (r_cnt == CW'(BEEP_LEN - 1)) begin
              w_state_next = D_OFF;
              w_cnt_next   = '0;
            end else begin
              w_cnt_next   = r_cnt + CW'(1);
            end
          end else if (r_state == D_GAP) begin
            if (r_cnt == CW'(GAP_LEN - 1)) begin
              w_state_next = D_ON;
              w_cnt_next   = '0;
            end else begin
              w_cnt_next   = r_cnt + CW'(1);
            end
          end else if (r_cnt != CW'(BEEP_LEN - 1)) begin
            w_cnt_next = r_cnt + CW'(1);
          end else begin
            // End of a D_OFF: next beep, next group, or pattern complete.
            w_cnt_next = '0;
            if (r_beep != BW'(BEEPS_PER_GROUP - 1)) begin
              w_beep_next  = r_beep + BW'(1);
              w_state_next = D_ON;
            end else if (r_group != GW'(BEEP_GROUPS - 1)) begin
              w_beep_next  = '0;
              w_group_next = r_group + GW'(1);
              w_state_next = D_GAP;
            end else begin
              w_beep_next  = '0;
              w_group_next = '0;
              w_state_next = IDLE;
            end
          end
        end
        default: begin
          w_state_next = IDLE;
          w_cnt_next   = '0;
          w_beep_next  = '0;
          w_group_next = '0;
        end
      endcase
    end
    w_buzzer_next = (w_state_next == D_ON);
`ifdef STAGE_PANEL_KEY_BEEP_EN
    if (w_state_next == KEY)
      w_buzzer_next = 1'b1;
`endif
    w_busy_next = (w_state_next != IDLE);
  end

  // Sequencer state, counters and run_state history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_beep     <= '0;
      r_group    <= '0;
      r_run_prev <= RS_IDLE;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_beep     <= w_beep_next;
      r_group    <= w_group_next;
      r_run_prev <= run_state;
    end
  end

  // Output registers; everything dark while unpowered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stage_light <= '0;
      r_start_light <= 1'b0;
      r_buzzer      <= 1'b0;
      r_busy        <= 1'b0;
    end else if (!power) begin
      r_stage_light <= '0;
      r_start_light <= 1'b0;
      r_buzzer      <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_stage_light <= w_stage_next;
      r_start_light <= (run_state == RS_RUN);
      r_buzzer      <= w_buzzer_next;
      r_busy        <= w_busy_next;
    end
  end

  assign stage_light = r_stage_light;
  assign start_light = r_start_light;
  assign buzzer      = r_buzzer;
  assign busy        = r_busy;

endmodule

// File: tb/tb_stage_panel.sv
// tb_stage_panel: scoreboard bench for stage_panel with a timeline reference
// model (blink age and pattern position arithmetic).
module tb_stage_panel;
  import panel_pkg::*;

  localparam int STAGES      = 3;
  localparam int CLK_HZ      = 8;
  localparam int BG          = 3;
  localparam int BPG         = 3;
  localparam int BEEP        = CLK_HZ / 4;
  localparam int GAP         = CLK_HZ / 2;
  localparam int HALF        = CLK_HZ / 2;
  localparam int GROUP_LEN   = BPG * 2 * BEEP;
  localparam int PERIOD      = GROUP_LEN + GAP;
  localparam int PATTERN_LEN = BG * GROUP_LEN + (BG - 1) * GAP;
`ifdef STAGE_PANEL_KEY_BEEP_EN
  localparam bit KEY_EN = 1'b1;
`else
  localparam bit KEY_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              power = 1'b0;
  logic [STAGES-1:0] stage_mask = '0;
  logic [1:0]        cur_stage = '0;
  run_state_t        run_state = RS_IDLE;
  logic              key_evt = 1'b0;
  logic [STAGES-1:0] stage_light;
  logic              start_light, buzzer, busy;

  stage_panel #(
    .STAGES(STAGES), .CLK_HZ(CLK_HZ), .BEEP_GROUPS(BG), .BEEPS_PER_GROUP(BPG)
  ) dut (
    .clk(clk), .reset(reset), .power(power), .stage_mask(stage_mask),
    .cur_stage(cur_stage), .run_state(run_state), .key_evt(key_evt),
    .stage_light(stage_light), .start_light(start_light), .buzzer(buzzer), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [STAGES-1:0] light;
    logic              start;
    logic              buzz;
    logic              busy;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   mon_cyc  = 0;

  // Reference model state: timeline positions rather than FSM states.
  run_state_t m_prev_rs = RS_IDLE;
  int         m_age  = 0;   // edges since last blink restart
  int         m_mode = 0;   // 0 silent, 1 key beep, 2 completion pattern
  int         m_pos  = 0;   // edges since the current beep sequence began

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, req, $time);
    end
  endtask

  // Expected outputs after the coming clock edge, given the inputs now applied.
  task automatic model_edge(output exp_t e);
    logic entry, done_edge;
    e = '0;
    if (!reset) begin
      m_prev_rs = RS_IDLE; m_age = 0; m_mode = 0; m_pos = 0;
      return;
    end
    entry     = (run_state == RS_RUN) && (m_prev_rs != RS_RUN);
    done_edge = power && (run_state == RS_DONE) && (m_prev_rs != RS_DONE);
    m_prev_rs = run_state;
    if (!power || entry) m_age = 0; else m_age++;
    if (!power) begin
      m_mode = 0; m_pos = 0;
    end else if (done_edge) begin
      m_mode = 2; m_pos = 0;
    end else if (m_mode == 2) begin
      if (run_state != RS_DONE) m_mode = 0;
      else begin m_pos++; if (m_pos >= PATTERN_LEN) m_mode = 0; end
    end else if (m_mode == 1) begin
      m_pos++; if (m_pos >= BEEP) m_mode = 0;
    end else if (KEY_EN && key_evt) begin
      m_mode = 1; m_pos = 0;
    end
    if (power) begin
      e.light = stage_mask;
      if (run_state == RS_RUN && cur_stage < STAGES)
        e.light[cur_stage] = ((m_age / HALF) % 2) == 0;
      e.start = (run_state == RS_RUN);
      e.busy  = (m_mode != 0);
      if (m_mode == 1) e.buzz = 1'b1;
      else if (m_mode == 2)
        e.buzz = ((m_pos % PERIOD) < GROUP_LEN) && (((m_pos % PERIOD) % (2 * BEEP)) < BEEP);
    end
  endtask

  // One clock of stimulus; an asserting reset is applied mid-cycle and checked at once.
  task automatic drive(input logic rst_n, input logic pwr, input logic [STAGES-1:0] mask,
                       input logic [1:0] cur, input int rs, input logic key);
    exp_t e;
    @(posedge clk); #1;
    if (!rst_n && reset) begin
      reset = 1'b0;
      foreach (exp_q[i]) exp_q[i] = '0;
      #1;
      check("async_reset", 32'({stage_light, start_light, buzzer, busy}), 32'd0);
    end
    reset      = rst_n;
    power      = pwr;
    stage_mask = mask;
    cur_stage  = cur;
    run_state  = run_state_t'(rs[1:0]);
    key_evt    = key;
    model_edge(e);
    exp_q.push_back(e);
  endtask

  task automatic run(input int n, input logic pwr, input logic [STAGES-1:0] mask,
                     input logic [1:0] cur, input int rs);
    repeat (n) drive(1'b1, pwr, mask, cur, rs, 1'b0);
  endtask

  // Monitor: one expected entry per clock, compared on the falling edge.
  initial begin
    exp_t e;
    wait (exp_q.size() > 0);
    @(posedge clk);
    forever begin
      @(negedge clk);
      mon_cyc++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_empty actual=0 required=1 entries at cycle %0d", mon_cyc);
      end else begin
        e = exp_q.pop_front();
        $display("cyc %0d light=%b start=%b buzz=%b busy=%b", mon_cyc,
                 stage_light, start_light, buzzer, busy);
        check("stage_light", 32'(stage_light), 32'(e.light));
        check("start_light", 32'(start_light), 32'(e.start));
        check("buzzer",      32'(buzzer),      32'(e.buzz));
        check("busy",        32'(busy),        32'(e.busy));
      end
    end
  end

  // Stimulus.
  initial begin
    int            rs_r, len;
    logic [2:0]    mask_r;
    logic [1:0]    cur_r;
    #1 reset = 1'b0;
    #1 check("reset_state", 32'({stage_light, start_light, buzzer, busy}), 32'd0);
    drive(1'b0, 1'b1, 3'b101, 2'd0, RS_IDLE, 1'b0);
    drive(1'b0, 1'b1, 3'b101, 2'd0, RS_IDLE, 1'b0);
    run(3, 1'b1, 3'b101, 2'd0, RS_IDLE);
    // Blinking running stage.
    run(3, 1'b1, 3'b111, 2'd1, RS_IDLE);
    run(20, 1'b1, 3'b111, 2'd1, RS_RUN);
    run(6, 1'b1, 3'b111, 2'd3, RS_RUN);
    run(3, 1'b1, 3'b011, 2'd1, RS_PAUSE);
    // Key beep from idle.
    drive(1'b1, 1'b1, 3'b011, 2'd1, RS_IDLE, 1'b1);
    run(5, 1'b1, 3'b011, 2'd1, RS_IDLE);
    // Full completion pattern, then hold done: no repeat.
    run(3, 1'b1, 3'b111, 2'd2, RS_RUN);
    run(55, 1'b1, 3'b111, 2'd2, RS_DONE);
    // Key during KEY, then completion at KEY cycle 1.
    run(2, 1'b1, 3'b111, 2'd0, RS_RUN);
    drive(1'b1, 1'b1, 3'b111, 2'd0, RS_RUN, 1'b1);
    drive(1'b1, 1'b1, 3'b111, 2'd0, RS_RUN, 1'b1);
    drive(1'b1, 1'b1, 3'b111, 2'd0, RS_DONE, 1'b1);
    run(50, 1'b1, 3'b111, 2'd0, RS_DONE);
    // Power loss at pattern cycle 10, restored with done held.
    run(2, 1'b1, 3'b110, 2'd1, RS_RUN);
    run(10, 1'b1, 3'b110, 2'd1, RS_DONE);
    run(3, 1'b0, 3'b110, 2'd1, RS_DONE);
    run(20, 1'b1, 3'b110, 2'd1, RS_DONE);
    // Abort by leaving done.
    run(2, 1'b1, 3'b110, 2'd1, RS_RUN);
    run(7, 1'b1, 3'b110, 2'd1, RS_DONE);
    run(4, 1'b1, 3'b110, 2'd1, RS_PAUSE);
    // Reset mid-pattern, then release.
    run(2, 1'b1, 3'b101, 2'd0, RS_RUN);
    run(8, 1'b1, 3'b101, 2'd0, RS_DONE);
    drive(1'b0, 1'b1, 3'b101, 2'd0, RS_DONE, 1'b0);
    drive(1'b0, 1'b1, 3'b101, 2'd0, RS_DONE, 1'b0);
    drive(1'b1, 1'b1, 3'b110, 2'd0, RS_IDLE, 1'b0);
    run(5, 1'b1, 3'b110, 2'd0, RS_IDLE);
    // Randomized segments.
    for (int s = 0; s < 60; s++) begin
      rs_r   = $urandom_range(0, 3);
      len    = $urandom_range(1, 50);
      mask_r = 3'($urandom);
      cur_r  = 2'($urandom);
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 9) == 0) cur_r = 2'($urandom);
        drive($urandom_range(0, 299) != 0, $urandom_range(0, 39) != 0,
              mask_r, cur_r, rs_r, $urandom_range(0, 7) == 0);
      end
    end
    repeat (2) @(posedge clk);
    #1 check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Run-time bound.
  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/stage_panel.md
STAGE_PANEL -- requirements
Module: stage_panel

Interface
REQ-001 SHALL have parameter STAGES, default 3, number of program-stage lights (2..8).
REQ-002 SHALL have parameter CLK_HZ, default 100_000_000, clk frequency; it sets all buzzer and blink timings.
REQ-003 SHALL have parameter BEEP_GROUPS, default 3, number of beep groups in the completion pattern.
REQ-004 SHALL have parameter BEEPS_PER_GROUP, default 3, number of beeps per completion group.
REQ-005 SHALL have port clk  in  1  system clock, all state on its rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous active-low reset.
REQ-007 SHALL have port power  in  1  panel powered; low forces every output low.
REQ-008 SHALL have port stage_mask  in  STAGES  stages in the selected mode, bit 0 = wash.
REQ-009 SHALL have port cur_stage  in  $clog2(STAGES)  index of the stage now executing.
REQ-010 SHALL have port run_state  in  2  0 idle, 1 run, 2 pause, 3 done.
REQ-011 SHALL have port key_evt  in  1  one-cycle pulse per debounced key press.
REQ-012 SHALL have port stage_light  out  STAGES  per-stage indicator.
REQ-013 SHALL have port start_light  out  1  high exactly while run_state==1 and power is high.
REQ-014 SHALL have port buzzer  out  1  buzzer drive.
REQ-015 SHALL have port busy  out  1  high while any beep sequence is in progress.

Function
REQ-016 SHALL register all outputs; each output reflects its inputs with exactly one clk of latency.
REQ-017 SHALL drive stage_light = stage_mask while run_state!=1.
REQ-018 SHALL, while run_state==1, drive stage_light = stage_mask with bit cur_stage replaced by the blink phase; a cur_stage >= STAGES leaves stage_light = stage_mask.
REQ-019 SHALL toggle the blink phase every CLK_HZ/2 cycles; the phase SHALL be forced high with its counter cleared on every entry into run_state==1.
REQ-020 SHALL implement buzzer FSM states IDLE, KEY, D_ON, D_OFF, D_GAP.
REQ-021 SHALL go IDLE->KEY on key_evt, then buzzer high for CLK_HZ/4 cycles, then return to IDLE.
REQ-022 SHALL go to D_ON on the cycle after run_state changes to 3 from any other value (edge detect, not level).
REQ-023 SHALL in the completion pattern hold D_ON for CLK_HZ/4 cycles (buzzer high) and D_OFF for CLK_HZ/4 cycles (buzzer low), repeated BEEPS_PER_GROUP times per group, with D_GAP of CLK_HZ/2 cycles (buzzer low) between groups and no gap after the final group.
REQ-024 SHALL give the completion edge priority: it aborts KEY and starts D_ON; key_evt during KEY or any D_* state is ignored.
REQ-025 SHALL abort the completion pattern to IDLE, with buzzer low on the next cycle, if run_state leaves 3.
REQ-026 SHALL, while power is low, hold the FSM in IDLE, clear all counters, hold all outputs low, and not register a completion edge.
REQ-027 SHALL size counters for CLK_HZ/2 so that they never wrap within a state.

Reset
REQ-028 SHALL on reset low immediately drive stage_light=0, start_light=0, buzzer=0, busy=0, FSM=IDLE, blink phase=1, all counters=0, and the run_state edge register=0.
REQ-029 SHALL remain in reset state for the whole time reset is low, including mid-pattern; release SHALL be synchronised to clk.

Configuration
REQ-030 SHALL, with macro STAGE_PANEL_KEY_BEEP_EN defined, implement KEY behaviour per REQ-021.
REQ-031 SHALL, without STAGE_PANEL_KEY_BEEP_EN, ignore key_evt and omit the KEY state; completion behaviour is unchanged.

Structure
REQ-032 SHALL take the run_state encoding typedef and the buzzer FSM state enum from shared package panel_pkg.
REQ-033 SHALL put the blink prescaler and phase in sub-module blink_gen (ports clk, reset, restart, phase).

Verification (CLK_HZ=8, STAGES=3, BEEP_GROUPS=3, BEEPS_PER_GROUP=3)
REQ-034 SHALL cover: stage_mask=3'b111, run_state 0->1, cur_stage=1 -> stage_light bit1 high 4 cycles, low 4 cycles, repeating; bits 0 and 2 steady 1; start_light=1.
REQ-035 SHALL cover: key_evt pulse while idle -> buzzer high exactly 2 cycles starting one cycle later, busy high for the same 2 cycles; without the macro, buzzer stays 0.
REQ-036 SHALL cover: run_state 1->3 -> 44-cycle pattern with 9 high pulses of 2 cycles each and 4-cycle gaps after beeps 3 and 6; holding run_state at 3 afterwards gives no repeat.
REQ-037 SHALL cover: key_evt during KEY, then run_state->3 at KEY cycle 1 -> KEY aborted, completion pattern starts the next cycle.
REQ-038 SHALL cover: power low at cycle 10 of the completion pattern -> all outputs 0 next cycle; power high again with run_state still 3 -> no beeps.
REQ-039 SHALL cover: reset low mid-pattern -> outputs 0 immediately, without waiting for a clk edge; after release, stage_light = stage_mask one cycle later.
